// File: rtl/wdata_mngr_pkg.sv
// Shared state encodings and sizing helpers for the AXI write-data burst manager.
package wdata_mngr_pkg;

   // Burst engine states. The encoding 2'd3 is unreachable and decodes to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_LAST  = 2'd2
   } wd_state_e;

   // Width of a beat index (and of the len field) for a given maximum burst length.
   function automatic int beat_cnt_w(input int max_beats);
      return (max_beats > 1) ? $clog2(max_beats) : 1;
   endfunction

endpackage

// File: rtl/wdata_req_fifo.sv
// Small request FIFO with fall-through: a push into an empty FIFO is visible at
// the head in the same cycle, so a consumer may pop it without a storage round trip.
module wdata_req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic             full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             empty;
   logic             pass_thru;
   logic             wr_en;
   logic             rd_en;

   // Pointer increment with wrap, so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty      = (count == '0);
   assign full       = (count == CNT_W'(DEPTH));
   assign head_valid = !empty || push;
   assign head_data  = empty ? push_data : mem[rd_ptr];

   // A push and pop on an empty FIFO hand the entry straight through.
   assign pass_thru = empty && push && pop;
   // A push into a full FIFO is dropped even if a pop happens in the same cycle.
   assign wr_en     = push && !full && !pass_thru;
   assign rd_en     = pop && !empty;

   // Entry storage, written on every stored push.
   // NOTE: the payload array has no reset; count and pointers define which words are valid,
   // so stale contents are never presented and the array can map onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values
   // regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (rd_en) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axi_wdata_burst_mngr.sv
// AXI write-data channel burst manager: queues {id, len, strb, payload} requests
// and replays each one as a W-channel burst, pulsing finish_wd after the last beat.
module axi_wdata_burst_mngr
   import wdata_mngr_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 4,
   parameter int ID_W      = 4,
   parameter int Q_DEPTH   = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   output logic                              wvalid,
   input  logic                              wready,
   output logic [DATA_W-1:0]                 wdata,
   output logic [DATA_W/8-1:0]               wstrb,
   output logic                              wlast,
   input  logic                              next_rq,
   output logic                              next_ready,
   input  logic [ID_W-1:0]                   next_id,
   input  logic [beat_cnt_w(MAX_BEATS)-1:0]  next_len,
   input  logic [DATA_W/8-1:0]               next_strb,
   input  logic [DATA_W*MAX_BEATS-1:0]       in_wdata,
   output logic                              finish_wd,
   output logic [ID_W-1:0]                   finish_id
);

   localparam int STRB_W = DATA_W / 8;
   localparam int LEN_W  = beat_cnt_w(MAX_BEATS);
   localparam int PAY_W  = DATA_W * MAX_BEATS;
   localparam int ENT_W  = ID_W + LEN_W + STRB_W + PAY_W;

   // Elaboration-time parameter range checks.
   if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
      $error("DATA_W must be 32 or 64");
   end
   if (MAX_BEATS < 2 || MAX_BEATS > 16 || (MAX_BEATS & (MAX_BEATS - 1)) != 0) begin : g_bad_beats
      $error("MAX_BEATS must be a power of two in 2..16");
   end
   if (Q_DEPTH < 1 || Q_DEPTH > 4) begin : g_bad_depth
      $error("Q_DEPTH must be in 1..4");
   end

   wd_state_e         state_q;
   wd_state_e         state_d;
   logic [LEN_W-1:0]  beat_q;
   logic [ID_W-1:0]   id_q;
   logic [LEN_W-1:0]  len_q;
   logic [STRB_W-1:0] strb_q;
   logic [PAY_W-1:0]  data_q;

   logic              pop;
   logic              beat_inc;
   logic              push;
   logic              fifo_full;
   logic              head_valid;
   logic [ENT_W-1:0]  head_entry;
   logic [ID_W-1:0]   head_id;
   logic [LEN_W-1:0]  head_len;
   logic [STRB_W-1:0] head_strb;
   logic [PAY_W-1:0]  head_data;
   logic              last_hs;

   // next_ready depends only on the registered occupancy inside the FIFO.
   assign next_ready = !fifo_full;
   assign push       = next_rq && next_ready;

   wdata_req_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (Q_DEPTH)
   ) u_req_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_data  ({next_id, next_len, next_strb, in_wdata}),
      .pop        (pop),
      .head_data  (head_entry),
      .head_valid (head_valid),
      .full       (fifo_full)
   );

   assign {head_id, head_len, head_strb, head_data} = head_entry;

   // W-channel outputs come straight from registered state, so they hold under backpressure.
   assign wvalid  = (state_q == ST_BURST) || (state_q == ST_LAST);
   assign wlast   = (state_q == ST_LAST);
   assign wstrb   = strb_q;
   assign wdata   = data_q[int'(beat_q) * DATA_W +: DATA_W];
   assign last_hs = (state_q == ST_LAST) && wready;

   // Next-state logic: start bursts from the queue head and chain them without idle cycles.
   // NOTE: every signal written here gets a default first, so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      beat_inc = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (head_valid) begin
               pop     = 1'b1;
               state_d = (head_len == '0) ? ST_LAST : ST_BURST;
            end
         end
         ST_BURST: begin
            if (wready) begin
               beat_inc = 1'b1;
               if (beat_q + LEN_W'(1) == len_q) begin
                  state_d = ST_LAST;
               end
            end
         end
         ST_LAST: begin
            if (wready) begin
               if (head_valid) begin
                  pop     = 1'b1;
                  state_d = (head_len == '0) ? ST_LAST : ST_BURST;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, beat counter and active-burst registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         id_q    <= '0;
         len_q   <= '0;
         strb_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (pop) begin
            beat_q <= '0;
            id_q   <= head_id;
            len_q  <= head_len;
            strb_q <= head_strb;
            data_q <= head_data;
         end else if (beat_inc) begin
            beat_q <= beat_q + LEN_W'(1);
         end
      end
   end

   // One-cycle completion pulse in the cycle after the final handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         finish_wd <= 1'b0;
         finish_id <= '0;
      end else begin
         finish_wd <= last_hs;
         if (last_hs) begin
            finish_id <= id_q;
         end
      end
   end

endmodule
